// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder
//   Valid/ready pipelined adder/subtractor. Operands are captured in stage 0.
//   Each following stage resolves one BLOCK-bit group with a flat carry-look-ahead.
//   The carry ripples only between stages, through a register.
//   Latency is NGRP+1 enabled cycles, and the block accepts one operand set per cycle.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand set present on a/b/ci/sub
//   in_ready   combinational; block accepts an operand set this cycle
//   a, b       WIDTH-bit operands
//   ci         carry-in; ignored when sub=1
//   sub        0 = a+b+ci, 1 = a-b
//   out_valid  s/co/ovf hold a result
//   out_ready  downstream accepts the result this cycle
//   s          registered sum/difference
//   co         registered carry-out of the MSB (for sub: 1 = no borrow)
//   ovf        registered two's-complement overflow
module pipelined_cla_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int unsigned NGRP = WIDTH / BLOCK;

    // Reject geometries where the groups do not tile the operand exactly.
    if (BLOCK == 0 || WIDTH == 0 || (WIDTH % BLOCK) != 0) begin : g_bad_params
        $error("pipelined_cla_adder: WIDTH must be a non-zero multiple of BLOCK");
    end

    // Group carries c[0..BLOCK] as a flat sum of products; no ripple inside the group.
    function automatic logic [BLOCK:0] cla_carries(
        input logic [BLOCK-1:0] x,
        input logic [BLOCK-1:0] y,
        input logic             cin
    );
        logic [BLOCK-1:0] p;
        logic [BLOCK-1:0] g;
        logic [BLOCK:0]   c;
        logic             t;
        p    = x ^ y;
        g    = x & y;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < int'(BLOCK); i++) begin
            // Carry-in propagated through p[0..i].
            t = cin;
            for (int k = 0; k <= i; k++) begin
                t = t & p[k];
            end
            c[i+1] = t;
            // Generate at bit j, propagated through p[j+1..i].
            for (int j = 0; j <= i; j++) begin
                t = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    t = t & p[k];
                end
                c[i+1] = c[i+1] | t;
            end
        end
        return c;
    endfunction

    // Pipeline state. Index 0 is the operand capture stage. Index g holds the
    // result after group g-1 is resolved. r_s[0] stays zero, so stage 1 has a
    // clean base to build on.
    logic             r_v [0:NGRP];
    logic [WIDTH-1:0] r_a [0:NGRP-1];
    logic [WIDTH-1:0] r_b [0:NGRP-1];
    logic             r_c [0:NGRP];
    logic [WIDTH-1:0] r_s [0:NGRP];
    logic             r_ovf;

    logic             w_en;
    logic [BLOCK:0]   w_car   [1:NGRP];
    logic [WIDTH-1:0] w_snext [1:NGRP];

    // One stall signal freezes every stage. This keeps ordering and occupancy
    // trivially correct.
    assign w_en     = !r_v[NGRP] || out_ready;
    assign in_ready = w_en;

    // Per-stage group look-ahead and partial-sum merge.
    always_comb begin
        for (int g = 1; g <= int'(NGRP); g++) begin
            w_car[g]   = cla_carries(r_a[g-1][(g-1)*BLOCK +: BLOCK],
                                     r_b[g-1][(g-1)*BLOCK +: BLOCK],
                                     r_c[g-1]);
            w_snext[g] = r_s[g-1];
            w_snext[g][(g-1)*BLOCK +: BLOCK] = r_a[g-1][(g-1)*BLOCK +: BLOCK]
                                             ^ r_b[g-1][(g-1)*BLOCK +: BLOCK]
                                             ^ w_car[g][BLOCK-1:0];
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g <= int'(NGRP); g++) begin
                r_v[g] <= 1'b0;
                r_c[g] <= 1'b0;
                r_s[g] <= '0;
            end
            for (int g = 0; g < int'(NGRP); g++) begin
                r_a[g] <= '0;
                r_b[g] <= '0;
            end
            r_ovf <= 1'b0;
        end else if (w_en) begin
            r_v[0] <= in_valid;
            if (in_valid) begin
                // Subtraction is a + ~b + 1, so the external ci is ignored.
                r_a[0] <= a;
                r_b[0] <= sub ? ~b : b;
                r_c[0] <= sub | ci;
            end
            for (int g = 1; g < int'(NGRP); g++) begin
                r_a[g] <= r_a[g-1];
                r_b[g] <= r_b[g-1];
            end
            for (int g = 1; g <= int'(NGRP); g++) begin
                r_v[g] <= r_v[g-1];
                r_c[g] <= w_car[g][BLOCK];
                r_s[g] <= w_snext[g];
            end
            // Overflow: carry into the MSB differs from carry out of the MSB.
            r_ovf <= w_car[NGRP][BLOCK] ^ w_car[NGRP][BLOCK-1];
        end
    end

    assign out_valid = r_v[NGRP];
    assign s         = r_s[NGRP];
    assign co        = r_c[NGRP];
    assign ovf       = r_ovf;

endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 The block SHALL provide parameter BLOCK, default 4: bits per carry-look-ahead group (one group per pipeline stage).
REQ-003 The block SHALL fail elaboration if WIDTH is not a non-zero multiple of BLOCK; NGRP = WIDTH/BLOCK.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  operand set present on a, b, ci, sub.
REQ-007 in_ready  output  1  block can accept an operand set this cycle.
REQ-008 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-009 b  input  WIDTH  operand B.
REQ-010 ci  input  1  carry-in, used only when sub=0.
REQ-011 sub  input  1  mode: 0 = add, 1 = subtract.
REQ-012 out_valid  output  1  s, co, ovf hold a valid result.
REQ-013 out_ready  input  1  downstream accepts the result this cycle.
REQ-014 s  output  WIDTH  registered sum/difference.
REQ-015 co  output  1  registered carry-out of MSB.
REQ-016 ovf  output  1  registered signed overflow flag.

Function
REQ-017 Transfer in SHALL occur on a rising edge where in_valid=1 and in_ready=1; transfer out where out_valid=1 and out_ready=1.
REQ-018 Global enable en = (!out_valid || out_ready); in_ready SHALL equal en combinationally; when en=0 every pipeline register (data and valid) SHALL hold.
REQ-019 Operands SHALL be registered on acceptance (stage 0); add: B'=b, carry-in=ci; sub: B'=~b, carry-in=1, ci ignored.
REQ-020 Stage g (g=1..NGRP) SHALL compute sum bits [g*BLOCK-1:(g-1)*BLOCK] with a BLOCK-bit CLA (generate/propagate, no ripple within group) using the carry registered by stage g-1, and register the group sum, group carry-out and the remaining operand bits.
REQ-021 Latency SHALL be NGRP+1 enabled cycles from input acceptance to out_valid (5 for defaults); throughput one result per cycle when out_ready=1.
REQ-022 co SHALL be the carry out of bit WIDTH-1 (for sub, co=1 means no borrow, i.e. a>=b unsigned).
REQ-023 ovf SHALL be 1 iff carry into bit WIDTH-1 differs from co.
REQ-024 Results SHALL emerge in acceptance order; no operand set SHALL be dropped or duplicated under any out_ready pattern.
REQ-025 Cycles with in_valid=0 while en=1 SHALL insert a bubble (valid=0) that advances like data; bubbles SHALL NOT raise out_valid.
REQ-026 s, co, ovf SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 Simultaneous output transfer and input acceptance in the same cycle SHALL be supported with no bubble inserted.

Reset
REQ-028 rst_n=0 SHALL immediately (asynchronously) clear all stage valid bits and all data registers; out_valid=0, s=0, co=0, ovf=0.
REQ-029 in_ready SHALL be 1 during and after reset (out_valid=0 implies en=1).
REQ-030 Reset asserted mid-operation SHALL discard all in-flight operations; no result from before reset SHALL appear after rst_n returns to 1.
REQ-031 Release of rst_n SHALL be taken synchronous to clk by the system; first acceptance possible on the first rising edge after release.

Verification (WIDTH=16, BLOCK=4, out_ready=1 unless stated)
REQ-032 a=0xFFFF, b=0x0001, ci=0, sub=0 -> after 5 cycles out_valid=1, s=0x0000, co=1, ovf=0.
REQ-033 a=0x0FFF, b=0x0000, ci=1, sub=0 -> s=0x1000, co=0, ovf=0 (carry crosses all group boundaries).
REQ-034 a=0x0005, b=0x0007, ci=1, sub=1 -> s=0xFFFE, co=0, ovf=0 (ci ignored); a=0x7FFF, b=0x0001, sub=0 -> s=0x8000, co=0, ovf=1.
REQ-035 Stream 10 random operand sets back-to-back, out_ready=0 for 3 cycles mid-stream -> in_ready=0 exactly while out_valid=1 and out_ready=0, outputs stable, all 10 results correct and in order.
REQ-036 Accept 3 operand sets, assert rst_n=0 for 1 cycle after the 2nd cycle -> outputs zero immediately, no out_valid pulse afterwards until new input; next accepted operation returns correct result 5 cycles later.
